// File: rtl/rob_commit_if.sv
// rob_commit_if: issue, CDB, operand-query and commit/flush signals of the
// reorder buffer. "master" is the core side (issue/execute), "slave" is the ROB.
interface rob_commit_if;
  // issue / allocation
  logic        issue_valid;
  logic        issue_has_dest;
  logic [4:0]  issue_rd;
  logic        issue_is_branch;
  logic [31:0] issue_tag;
  logic        rob_full;
  // common data bus
  logic        cdb_valid;
  logic [31:0] cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  // operand tag queries
  logic [31:0] query_tag_1;
  logic [31:0] query_tag_2;
  logic        query_ready_1;
  logic        query_ready_2;
  logic [31:0] query_value_1;
  logic [31:0] query_value_2;
  // register-file commit port and flush
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [31:0] commit_tag;
  logic        clear;
  logic [31:0] redirect_pc;

  modport master (
    output issue_valid, issue_has_dest, issue_rd, issue_is_branch,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target,
    output query_tag_1, query_tag_2,
    input  issue_tag, rob_full,
    input  query_ready_1, query_ready_2, query_value_1, query_value_2,
    input  commit_en, commit_rd, commit_value, commit_tag, clear, redirect_pc
  );

  modport slave (
    input  issue_valid, issue_has_dest, issue_rd, issue_is_branch,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target,
    input  query_tag_1, query_tag_2,
    output issue_tag, rob_full,
    output query_ready_1, query_ready_2, query_value_1, query_value_2,
    output commit_en, commit_rd, commit_value, commit_tag, clear, redirect_pc
  );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with in-order commit for the Tomasulo core.
// Allocates entries at the tail, captures CDB results, retires the head in
// program order and flushes everything on a mispredicted branch at the head.
// Optional macro ROB_QUERY_BYPASS_EN: operand queries also see the
// same-cycle CDB broadcast.
module rob_commit #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned TAG_W     = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  rob_commit_if.slave  bus
);

  // ---------------- local copies of interface inputs ----------------
  logic        issue_valid, issue_has_dest, issue_is_branch;
  logic [4:0]  issue_rd;
  logic        cdb_valid, cdb_mispredict;
  logic [31:0] cdb_tag, cdb_value, cdb_target;

  assign issue_valid     = bus.issue_valid;
  assign issue_has_dest  = bus.issue_has_dest;
  assign issue_rd        = bus.issue_rd;
  assign issue_is_branch = bus.issue_is_branch;
  assign cdb_valid       = bus.cdb_valid;
  assign cdb_tag         = bus.cdb_tag;
  assign cdb_value       = bus.cdb_value;
  assign cdb_mispredict  = bus.cdb_mispredict;
  assign cdb_target      = bus.cdb_target;

  // ---------------- state ----------------
  logic [ROB_DEPTH-1:0] busy_q, busy_d;
  logic [ROB_DEPTH-1:0] ready_q, ready_d;
  logic [ROB_DEPTH-1:0] has_dest_q, has_dest_d;
  logic [ROB_DEPTH-1:0] is_branch_q, is_branch_d;
  logic [ROB_DEPTH-1:0] mispredict_q, mispredict_d;
  logic [4:0]           rd_q     [ROB_DEPTH];
  logic [4:0]           rd_d     [ROB_DEPTH];
  logic [31:0]          value_q  [ROB_DEPTH];
  logic [31:0]          value_d  [ROB_DEPTH];
  logic [31:0]          target_q [ROB_DEPTH];
  logic [31:0]          target_d [ROB_DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic        commit_en_q, commit_en_d;
  logic [4:0]  commit_rd_q, commit_rd_d;
  logic [31:0] commit_value_q, commit_value_d;
  logic [31:0] commit_tag_q, commit_tag_d;
  logic        clear_q, clear_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  // ---------------- derived control ----------------
  logic             rob_full;
  logic [TAG_W-1:0] cdb_idx;
  logic             cdb_in_range;
  logic             cdb_hit;
  logic             do_commit;
  logic             do_flush;
  logic             do_alloc;

  assign rob_full     = (count_q == (TAG_W+1)'(ROB_DEPTH));
  assign cdb_idx      = cdb_tag[TAG_W-1:0];
  assign cdb_in_range = (cdb_tag[31:TAG_W] == '0);
  assign cdb_hit      = cdb_valid && cdb_in_range && busy_q[cdb_idx];
  assign do_commit    = busy_q[head_q] && ready_q[head_q];
  assign do_flush     = do_commit && is_branch_q[head_q] && mispredict_q[head_q];
  assign do_alloc     = issue_valid && !rob_full && !do_flush;

  // Next-state: writeback, then commit frees head, then allocate at tail;
  // a head mispredict overrides everything with a full flush.
  always_comb begin
    busy_d         = busy_q;
    ready_d        = ready_q;
    has_dest_d     = has_dest_q;
    is_branch_d    = is_branch_q;
    mispredict_d   = mispredict_q;
    rd_d           = rd_q;
    value_d        = value_q;
    target_d       = target_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_en_d    = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    clear_d        = 1'b0;
    redirect_pc_d  = redirect_pc_q;

    if (rdy_in) begin
      if (cdb_hit) begin
        ready_d[cdb_idx]      = 1'b1;
        value_d[cdb_idx]      = cdb_value;
        mispredict_d[cdb_idx] = cdb_mispredict;
        target_d[cdb_idx]     = cdb_target;
      end

      if (do_commit) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
        if (has_dest_q[head_q] && (rd_q[head_q] != 5'd0)) begin
          commit_en_d    = 1'b1;
          commit_rd_d    = rd_q[head_q];
          commit_value_d = value_q[head_q];
          commit_tag_d   = 32'(head_q);
        end
      end

      if (do_alloc) begin
        busy_d[tail_q]       = 1'b1;
        ready_d[tail_q]      = 1'b0;
        has_dest_d[tail_q]   = issue_has_dest;
        is_branch_d[tail_q]  = issue_is_branch;
        mispredict_d[tail_q] = 1'b0;
        rd_d[tail_q]         = issue_rd;
        value_d[tail_q]      = '0;
        target_d[tail_q]     = '0;
        tail_d               = tail_q + TAG_W'(1);
      end

      count_d = count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);

      if (do_flush) begin
        busy_d        = '0;
        ready_d       = '0;
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
        clear_d       = 1'b1;
        redirect_pc_d = target_q[head_q];
      end
    end
  end

  // State and registered commit/flush outputs; async active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      has_dest_q     <= '0;
      is_branch_q    <= '0;
      mispredict_q   <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]     <= '0;
        value_q[i]  <= '0;
        target_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      clear_q        <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      has_dest_q     <= has_dest_d;
      is_branch_q    <= is_branch_d;
      mispredict_q   <= mispredict_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      target_q       <= target_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_en_q    <= commit_en_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      clear_q        <= clear_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  // Operand lookup: {ready, value} for a tag; out-of-range tags never hit.
  function automatic logic [32:0] lookup(input logic [31:0] tag);
    logic [TAG_W-1:0] idx;
    lookup = '0;
    idx    = tag[TAG_W-1:0];
    if ((tag[31:TAG_W] == '0) && busy_q[idx]) begin
      if (ready_q[idx]) begin
        lookup = {1'b1, value_q[idx]};
      end
`ifdef ROB_QUERY_BYPASS_EN
      else if (cdb_valid && (cdb_tag == tag)) begin
        lookup = {1'b1, cdb_value};
      end
`endif
    end
  endfunction

  logic [32:0] q1_res, q2_res;

  // Combinational answers to the two issue-stage operand queries.
  always_comb begin
    q1_res = lookup(bus.query_tag_1);
    q2_res = lookup(bus.query_tag_2);
  end

  assign bus.query_ready_1 = q1_res[32];
  assign bus.query_value_1 = q1_res[31:0];
  assign bus.query_ready_2 = q2_res[32];
  assign bus.query_value_2 = q2_res[31:0];

  assign bus.issue_tag    = 32'(tail_q);
  assign bus.rob_full     = rob_full;
  assign bus.commit_en    = commit_en_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_value = commit_value_q;
  assign bus.commit_tag   = commit_tag_q;
  assign bus.clear        = clear_q;
  assign bus.redirect_pc  = redirect_pc_q;

endmodule
